// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 2x16 text writer: panel command bytes,
// the main sequencing FSM state type and the byte-strobe phase type.
// -----------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] CMD_ENTRY    = 8'h06;  // increment address, no shift
    localparam logic [7:0] CMD_CLEAR    = 8'h01;  // clear display, home cursor
    localparam logic [7:0] CMD_LINE1    = 8'h80;  // DDRAM address 0x00
    localparam logic [7:0] CMD_LINE2    = 8'hC0;  // DDRAM address 0x40
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    localparam int BUF_DEPTH = 32;

    typedef enum logic [2:0] {
        ST_POWER_WAIT,
        ST_INIT,
        ST_CLR_WAIT,
        ST_L1_ADDR,
        ST_L1_DATA,
        ST_L2_ADDR,
        ST_L2_DATA
    } main_state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } byte_phase_e;

    // Init command sequence, sent in index order 0..3.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = CMD_FUNC_SET;
            2'd1:    cmd = CMD_DISP_ON;
            2'd2:    cmd = CMD_ENTRY;
            default: cmd = CMD_CLEAR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// -----------------------------------------------------------------------------
// lcd_byte_tx
// Three-phase LCD byte strobe: SETUP (e=0, rs/data loaded), PULSE (e=1),
// HOLD (e=0). rs/data are held from SETUP through HOLD and beyond, until the
// next start. A start seen during HOLD chains the next byte with no gap.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           load rs/data on this edge and begin SETUP
//   rs, data        register select and byte for the transfer being started
//   lcd_e           enable strobe (high only in PULSE)
//   lcd_rs, lcd_data  registered bus values
//   done            high during the HOLD cycle
// -----------------------------------------------------------------------------
module lcd_byte_tx
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done
);

    logic        busy_q,  busy_d;
    byte_phase_e phase_q, phase_d;
    logic        e_q,     e_d;
    logic        rs_q,    rs_d;
    logic [7:0]  data_q,  data_d;

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        e_d     = 1'b0;
        rs_d    = rs_q;
        data_d  = data_q;
        if (start) begin
            busy_d  = 1'b1;
            phase_d = PH_SETUP;
            rs_d    = rs;
            data_d  = data;
        end else if (busy_q) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_PULSE;
                    e_d     = 1'b1;
                end
                PH_PULSE: phase_d = PH_HOLD;
                default: begin
                    busy_d  = 1'b0;
                    phase_d = PH_SETUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            phase_q <= PH_SETUP;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign done     = busy_q && (phase_q == PH_HOLD);

endmodule

// File: rtl/lcd_text_writer.sv
// -----------------------------------------------------------------------------
// lcd_text_writer
// HD44780 2x16 character LCD controller. Holds a 32-byte text buffer, runs
// the power-on init sequence, then refreshes both lines from the buffer
// forever with no idle gap between frames.
//
// Ports:
//   clk, rst           1 kHz clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  buffer write port (addr 0-15 line 1, 16-31 line 2)
//   lcd_e/lcd_rs/lcd_rw/lcd_data  panel bus (rw tied low, write-only)
//   init_done          high from the first line-1 address command onward
//   frame_done         high during HOLD of the last line-2 character
// -----------------------------------------------------------------------------
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int POWER_ON_CYCLES = 30,
    parameter int CLEAR_WAIT      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int CNT_W = 16;

    logic [7:0]  char_buf_q [BUF_DEPTH];
    logic [7:0]  char_buf_d [BUF_DEPTH];

    main_state_e state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic        init_done_q, init_done_d;

    logic        tx_start;
    logic        tx_rs;
    logic [7:0]  tx_data;
    logic        tx_done;

    // Buffer write. Reads below use char_buf_q, so a write landing on the same
    // edge as a character's SETUP sends the old value.
    always_comb begin
        char_buf_d = char_buf_q;
        if (wr_en) begin
            char_buf_d[wr_addr] = wr_data;
        end
    end

    // Sequencer: each start issued here is registered by lcd_byte_tx on the
    // next edge, so a start raised during a HOLD cycle makes the next SETUP
    // follow immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        tx_start    = 1'b0;
        tx_rs       = 1'b0;
        tx_data     = 8'h00;
        case (state_q)
            ST_POWER_WAIT: begin
                // cnt_q equals the number of edges since reset release.
                if (cnt_q >= CNT_W'(POWER_ON_CYCLES)) begin
                    tx_start = 1'b1;
                    tx_data  = init_cmd(2'd0);
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                if (tx_done) begin
                    if (cnt_q < CNT_W'(3)) begin
                        tx_start = 1'b1;
                        tx_data  = init_cmd(cnt_q[1:0] + 2'd1);
                        cnt_d    = cnt_q + 1'b1;
                    end else begin
                        state_d = ST_CLR_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_CLR_WAIT: begin
                // At least one idle cycle is always spent here.
                if ((cnt_q + 1'b1) >= CNT_W'(CLEAR_WAIT)) begin
                    tx_start    = 1'b1;
                    tx_data     = CMD_LINE1;
                    state_d     = ST_L1_ADDR;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_L1_ADDR: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    tx_rs    = 1'b1;
                    tx_data  = char_buf_q[0];
                    state_d  = ST_L1_DATA;
                    cnt_d    = '0;
                end
            end
            ST_L1_DATA: begin
                // cnt_q[4:0] is the buffer address currently on the bus.
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (cnt_q[4:0] == 5'd15) begin
                        tx_data = CMD_LINE2;
                        state_d = ST_L2_ADDR;
                    end else begin
                        tx_rs   = 1'b1;
                        tx_data = char_buf_q[cnt_q[4:0] + 5'd1];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            ST_L2_ADDR: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    tx_rs    = 1'b1;
                    tx_data  = char_buf_q[16];
                    state_d  = ST_L2_DATA;
                    cnt_d    = CNT_W'(16);
                end
            end
            ST_L2_DATA: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (cnt_q[4:0] == 5'd31) begin
                        tx_data = CMD_LINE1;
                        state_d = ST_L1_ADDR;
                        cnt_d   = '0;
                    end else begin
                        tx_rs   = 1'b1;
                        tx_data = char_buf_q[cnt_q[4:0] + 5'd1];
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_POWER_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_POWER_WAIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                char_buf_q[i] <= CHAR_SPACE;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            char_buf_q  <= char_buf_d;
        end
    end

    lcd_byte_tx u_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .start    (tx_start),
        .rs       (tx_rs),
        .data     (tx_data),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data),
        .done     (tx_done)
    );

    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign frame_done = (state_q == ST_L2_DATA) && (cnt_q[4:0] == 5'd31) && tx_done;

endmodule

// File: tb/tb_lcd_text_writer.sv
module tb_lcd_text_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0] lcd_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = -1;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;   // SETUP cycle
    } exp_t;

    exp_t exp_q[$];

    lcd_text_writer #(.POWER_ON_CYCLES(30), .CLEAR_WAIT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycle 0 is the first posedge with rst high.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= -1;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        int g = 0;
        while (cyc < n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < n) check("wait_timeout", cyc, n);
    endtask

    task automatic push(input logic rs_v, input logic [7:0] d, input int c);
        exp_t e;
        e.rs = rs_v; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 30);
        push(1'b0, 8'h0C, 33);
        push(1'b0, 8'h06, 36);
        push(1'b0, 8'h01, 39);
    endtask

    // Frame starting with 0x80 SETUP at cycle f; only the first nbytes pushed.
    task automatic push_frame(input int f, input logic [7:0] c0, input logic [7:0] c5,
                              input logic [7:0] c16, input int nbytes);
        logic [7:0] ch;
        int         a;
        for (int k = 0; k < nbytes; k++) begin
            if (k == 0)       push(1'b0, 8'h80, f);
            else if (k == 17) push(1'b0, 8'hC0, f + 51);
            else begin
                a  = (k <= 16) ? (k - 1) : (k - 2);
                ch = (a == 0) ? c0 : (a == 5) ? c5 : (a == 16) ? c16 : 8'h20;
                push(1'b1, ch, f + 3 * k);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Monitor: each lcd_e pulse is one byte; compare against scoreboard.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst && lcd_e) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", {23'd0, lcd_rs, lcd_data}, 32'h1FF);
                        end else begin
                            e = exp_q.pop_front();
                            check("byte_rs",    int'(lcd_rs), int'(e.rs));
                            check("byte_data",  int'(lcd_data), int'(e.data));
                            check("byte_cycle", cyc - 1, e.cyc);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", {lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done}, 0);

        push_init();
        push_frame(44,  8'h48, 8'h20, 8'h69, 34);
        push_frame(146, 8'h48, 8'h20, 8'h69, 34);
        push_frame(248, 8'h48, 8'h41, 8'h69, 22);
        rst = 1'b1;

        for (int c = 0; c < 30; c++) begin
            wait_cyc(c);
            check("power_wait_idle", {lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done}, 0);
            if (c == 5) begin wr_en = 1'b1; wr_addr = 5'd0;  wr_data = 8'h48; end
            if (c == 6) begin wr_en = 1'b1; wr_addr = 5'd16; wr_data = 8'h69; end
            if (c == 7) wr_en = 1'b0;
        end

        wait_cyc(30);
        check("c30_setup", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h38});
        wait_cyc(31);
        check("c31_pulse", {lcd_e, lcd_rs, lcd_data}, {2'b10, 8'h38});
        wait_cyc(32);
        check("c32_hold",  {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h38});
        wait_cyc(42);
        check("clr_wait_e42", int'(lcd_e), 0);
        wait_cyc(43);
        check("clr_wait_e43", int'(lcd_e), 0);
        check("init_done_43", int'(init_done), 0);
        wait_cyc(44);
        check("init_done_44", int'(init_done), 1);
        check("line1_cmd_44", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h80});
        wait_cyc(144);
        check("frame_done_144", int'(frame_done), 0);
        wait_cyc(145);
        check("frame_done_145", int'(frame_done), 1);
        wait_cyc(146);
        check("frame_done_146", int'(frame_done), 0);
        check("line1_cmd_146", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h80});
        check("rw_low", int'(lcd_rw), 0);

        // Write lands on the very edge buffer[5] is sampled (SETUP at 164).
        wait_cyc(163);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h41;
        wait_cyc(164);
        wr_en = 1'b0;

        // Reset during PULSE of line-2 column 3 (SETUP 311).
        wait_cyc(312);
        #1;
        check("pre_reset_pulse", int'(lcd_e), 1);
        rst = 1'b0;
        #1;
        check("async_rst_e",    int'(lcd_e), 0);
        check("async_rst_data", int'(lcd_data), 0);
        check("async_rst_init", int'(init_done), 0);
        check("pending_before_reset", exp_q.size(), 0);

        @(negedge clk);
        push_init();
        push_frame(44,  8'h20, 8'h20, 8'h20, 34);
        push_frame(146, 8'h20, 8'h20, 8'h20, 1);
        rst = 1'b1;

        wait_cyc(29);
        check("restart_idle_29", {lcd_e, lcd_rs, lcd_data, init_done}, 0);
        wait_cyc(30);
        check("restart_c30", {lcd_e, lcd_rs, lcd_data}, {2'b00, 8'h38});
        wait_cyc(148);
        check("pending_at_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Character-LCD controller for the HD44780-compatible 2×16 text panel on the board, clocked from the 1 kHz system clock. It holds a 32-byte display buffer written by the mode/state logic and owns the lcd_e / lcd_rs / lcd_rw / lcd_data pins. It runs the power-on initialisation sequence, then continuously refreshes both panel lines from the buffer. It drives the LCD bus that the top-level mode logic currently leaves as a stub.

## Interface
Parameters:
- POWER_ON_CYCLES, 30, idle clk cycles after reset release before the first command (30 ms at 1 kHz).
- CLEAR_WAIT, 2, extra idle cycles after the Clear Display command.

Ports:
- clk  in  1  1 kHz system clock; one clock, all logic on posedge clk.
- rst  in  1  reset, asynchronous, active-low; rst=0 resets everything immediately.
- wr_en  in  1  buffer write strobe, sampled on posedge clk.
- wr_addr  in  5  buffer address; 0–15 is line 1 columns 0–15, 16–31 is line 2 columns 0–15.
- wr_data  in  8  ASCII character.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 selects a command, 1 selects data.
- lcd_rw  out  1  tied to 0 (write-only; the busy flag is never read).
- lcd_data  out  8  LCD data bus.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- frame_done  out  1  one-cycle pulse at the end of each full two-line refresh.

## Operation
- Buffer: 32×8 registers, all reset to 0x20 (space).
  - When wr_en=1, wr_data is written at wr_addr on the next edge.
  - Every 5-bit address is valid.
- Byte transfer: every byte uses 3 cycles.
  - SETUP: lcd_e=0; lcd_rs and lcd_data are loaded.
  - PULSE: lcd_e=1.
  - HOLD: lcd_e=0.
  - lcd_rs and lcd_data stay stable from SETUP through HOLD.
- Main FSM states: POWER_WAIT → INIT → CLR_WAIT → L1_ADDR → L1_DATA → L2_ADDR → L2_DATA, then back to L1_ADDR forever.
  - POWER_WAIT: counts POWER_ON_CYCLES cycles with all outputs at 0.
  - INIT: sends commands with rs=0, in order: 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear).
  - CLR_WAIT: CLEAR_WAIT idle cycles with lcd_e=0.
  - L1_ADDR: command 0x80 (rs=0).
  - L1_DATA: buffer[0..15] with rs=1.
  - L2_ADDR: command 0xC0 (rs=0).
  - L2_DATA: buffer[16..31] with rs=1.
- Character sampling: each character is read from the buffer on its SETUP cycle edge.
- Write/read collision: if a write to that same address occurs on the same edge, the old value is sent. The new value appears on the next frame.
- init_done rises on the first L1_ADDR SETUP cycle.
- frame_done is high during the HOLD cycle of buffer[31].
- Reset mid-operation (rst=0 at any point):
  - Outputs go to 0 asynchronously and the buffer returns to spaces.
  - After release, the full sequence restarts, including POWER_WAIT.
  - A byte interrupted mid-transfer is abandoned.

## Timing
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, init_done=0, frame_done=0.
- Cycle numbering below counts from cycle 0 = the first posedge with rst=1.
- Default-parameter schedule:
  - Cycles 0–29: POWER_WAIT.
  - 30–32: byte 0x38.
  - 33–35: byte 0x0C.
  - 36–38: byte 0x06.
  - 39–41: byte 0x01.
  - 42–43: CLR_WAIT.
  - 44: SETUP of 0x80; init_done=1 from this cycle.
- Frame: 34 bytes × 3 cycles = 102 cycles.
  - First frame spans cycles 44–145; frame_done=1 at cycle 145.
  - Next 0x80 SETUP is at cycle 146.
  - Frame period is 102 cycles, with no idle gaps between frames.
- Write latency: a write lands in the buffer one edge after wr_en and reaches the panel at that address's next SETUP. Worst case is about 102 cycles.

## Structure
- Package lcd_pkg holds:
  - Command constants: CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_LINE1=0x80, CMD_LINE2=0xC0, CHAR_SPACE=0x20.
  - The main FSM state enum.
  - The byte-phase enum (SETUP/PULSE/HOLD).
- Sub-module lcd_byte_tx implements the 3-phase byte strobe.
  - Inputs: start, rs, data.
  - Outputs: lcd_e, lcd_rs, lcd_data, and a done pulse on HOLD.
  - The top FSM sequences bytes through it.

## Test plan
- Reset release, idle inputs → cycles 0–29 all outputs 0; cycle 30 lcd_data=0x38, rs=0, e=0; cycle 31 e=1; cycle 32 e=0.
- Init sequence → bytes 0x38, 0x0C, 0x06, 0x01 at cycles 30/33/36/39 with rs=0; e low during cycles 42–43; init_done rises at cycle 44 with lcd_data=0x80.
- Empty buffer, one frame → 0x80, then 16×0x20 with rs=1, then 0xC0, then 16×0x20; frame_done single-cycle pulse at cycle 145; 0x80 again at cycle 146.
- Write 0x48 at addr 0 and 0x69 at addr 16 during POWER_WAIT → first frame sends line-1 column 0 = 0x48 and line-2 column 0 = 0x69; all other characters are 0x20.
- Write 0x41 to addr 5 on the exact SETUP edge of buffer[5] → that frame sends 0x20; the next frame sends 0x41 at that slot.
- rst=0 during the PULSE of a line-2 character → lcd_e=0 and lcd_data=0x00 immediately; init_done=0; after release the first 0x38 appears at cycle 30 and the buffer reads back all spaces.
